// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the event-counter display path.
//   DEF_BIN_W   : default width of the binary count fed to the converter
//   DEF_DIGITS  : default number of packed BCD digits produced
//   DEF_MAX_VAL : largest displayable value (10^DEF_DIGITS - 1)
//   CNT_W       : width of the converter's bit counter
//   state_e     : converter FSM encoding (IDLE=0, SHIFT=1)
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam int DEF_BIN_W   = 14;
    localparam int DEF_DIGITS  = 4;
    localparam int DEF_MAX_VAL = 9999;

    localparam int CNT_W = $clog2(DEF_BIN_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage : counter_pkg

// File: rtl/bcd_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3
// Combinational double-dabble digit adjust: a digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next decade.
//   din  [3:0] : scratch digit before the shift
//   dout [3:0] : adjusted digit
// ----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule : bcd_add3

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. Inputs above MAX_VAL saturate to MAX_VAL and raise ovf.
//
// Handshake: a conversion is accepted on any rising edge where start=1 and
// the block is idle (busy=0); bin_in is sampled only on that edge. start
// while busy is ignored (no queuing). done pulses for exactly one cycle when
// bcd_out/ovf update; those outputs hold their value between done pulses.
//
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   start   : conversion request
//   bin_in  : binary operand [BIN_W-1:0]
//   busy    : conversion in progress
//   done    : one-cycle result strobe
//   bcd_out : packed BCD [4*DIGITS-1:0], [3:0] = units
//   ovf     : last accepted operand exceeded MAX_VAL
// ----------------------------------------------------------------------------
module bin2bcd_seq
    import counter_pkg::*;
#(
    parameter int BIN_W   = DEF_BIN_W,
    parameter int DIGITS  = DEF_DIGITS,
    parameter int MAX_VAL = DEF_MAX_VAL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int                 BCD_W   = 4 * DIGITS;
    localparam int                 BITC_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [BIN_W-1:0]   MAX_VEC = BIN_W'(MAX_VAL);
    localparam logic [BITC_W-1:0]  LAST_BIT = BITC_W'(BIN_W - 1);

    state_e              state_q,   state_d;
    logic [BIN_W-1:0]    op_q,      op_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [BITC_W-1:0]   cnt_q,     cnt_d;
    logic                pend_q,    pend_d;
    logic [BCD_W-1:0]    bcd_q,     bcd_d;
    logic                ovf_q,     ovf_d;
    logic                done_q,    done_d;

    logic [BCD_W-1:0]    adj;

    // Per-digit adjust of the scratch register, applied before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .din  (scratch_q[4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Saturating keeps the top digit from ever carrying out.
                    if (bin_in > MAX_VEC) begin
                        op_d   = MAX_VEC;
                        pend_d = 1'b1;
                    end else begin
                        op_d   = bin_in;
                        pend_d = 1'b0;
                    end
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = {adj[BCD_W-2:0], op_q[BIN_W-1]};
                op_d      = {op_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Publish the fully shifted value directly so bcd_out
                    // never exposes a partial scratch pattern.
                    bcd_d   = scratch_d;
                    ovf_d   = pend_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin2bcd_seq
// Directed bench for bin2bcd_seq with a decimal-division reference model.
// ----------------------------------------------------------------------------
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] bin_in;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        ovf;

    int checks;
    int failures;

    // {ovf, bcd} of each accepted conversion, oldest first
    logic [16:0] exp_q[$];

    bin2bcd_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: saturate then split into decimal digits by division.
    function automatic logic [16:0] ref_model(input int v);
        int d;
        logic [15:0] b;
        d = (v > 9999) ? 9999 : v;
        b[15:12] = 4'((d / 1000) % 10);
        b[11:8]  = 4'((d / 100) % 10);
        b[7:4]   = 4'((d / 10) % 10);
        b[3:0]   = 4'(d % 10);
        return {(v > 9999), b};
    endfunction

    // ---------------- driver ----------------
    // One isolated conversion. disturb=1 pulses start and scrambles bin_in
    // mid-conversion; both must be ignored.
    task automatic do_conv(input logic [13:0] v, input bit disturb);
        logic [15:0] prev_bcd;
        logic [16:0] e;
        int busy_cnt;
        int lat;
        bit got;
        bit hold_bad;
        prev_bcd = bcd_out;
        busy_cnt = 0;
        lat      = 0;
        got      = 1'b0;
        hold_bad = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        exp_q.push_back(ref_model(int'(v)));
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (c > 1) @(negedge clk);
            if (disturb && c == 5) begin
                start  = 1'b1;
                bin_in = ~v;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                lat = c;
            end else if (bcd_out !== prev_bcd) begin
                hold_bad = 1'b1;
            end
        end
        start = 1'b0;
        check_eq("done_seen", 32'(got), 32'd1);
        check_eq("latency", 32'(lat), 32'd15);
        check_eq("busy_cycles", 32'(busy_cnt), 32'd14);
        check_eq("hold_between_done", 32'(hold_bad), 32'd0);
        e = exp_q.pop_front();
        check_eq("bcd_out", 32'(bcd_out), 32'(e[15:0]));
        check_eq("ovf", 32'(ovf), 32'(e[16]));
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("bcd_hold_after", 32'(bcd_out), 32'(e[15:0]));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [16:0] e;
        int since;
        bit got;
        int done_cnt;
        logic [13:0] held_vals[3];
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        start    = 1'b0;
        bin_in   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_bcd", 32'(bcd_out), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // basic values
        do_conv(14'd0, 1'b0);
        check_eq("bcd_0", 32'(bcd_out), 32'h0000);
        do_conv(14'd1234, 1'b0);
        check_eq("bcd_1234", 32'(bcd_out), 32'h1234);
        do_conv(14'd9999, 1'b0);
        check_eq("bcd_9999", 32'(bcd_out), 32'h9999);
        do_conv(14'd5, 1'b1);
        check_eq("bcd_5_disturbed", 32'(bcd_out), 32'h0005);

        // overflow saturates, next in-range conversion clears ovf
        do_conv(14'd12000, 1'b0);
        check_eq("bcd_sat", 32'(bcd_out), 32'h9999);
        check_eq("ovf_set", 32'(ovf), 32'd1);
        do_conv(14'd42, 1'b0);
        check_eq("bcd_42", 32'(bcd_out), 32'h0042);
        check_eq("ovf_clear", 32'(ovf), 32'd0);
        do_conv(14'd12000, 1'b0);

        // reset in the middle of a conversion of 4321
        @(negedge clk);
        start  = 1'b1;
        bin_in = 14'd4321;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_bcd", 32'(bcd_out), 32'd0);
        check_eq("abort_ovf", 32'(ovf), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) got = 1'b1;
        end
        check_eq("abort_no_done", 32'(got), 32'd0);
        do_conv(14'd4321, 1'b0);
        check_eq("bcd_4321", 32'(bcd_out), 32'h4321);

        // start held high: back-to-back every 15 cycles
        held_vals[0] = 14'd7;
        held_vals[1] = 14'd8;
        held_vals[2] = 14'd9;
        @(negedge clk);
        start  = 1'b1;
        bin_in = held_vals[0];
        exp_q.push_back(ref_model(7));
        done_cnt = 0;
        since    = 0;
        for (int c = 0; c < 80 && done_cnt < 3; c++) begin
            @(negedge clk);
            since++;
            if (since == 6) bin_in = 14'h2AAA;
            if (done) begin
                e = exp_q.pop_front();
                check_eq("held_interval", 32'(since), 32'd15);
                check_eq("held_bcd", 32'(bcd_out), 32'(e[15:0]));
                check_eq("held_ovf", 32'(ovf), 32'(e[16]));
                done_cnt++;
                since = 0;
                if (done_cnt < 3) begin
                    bin_in = held_vals[done_cnt];
                    exp_q.push_back(ref_model(int'(held_vals[done_cnt])));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_eq("held_done_count", 32'(done_cnt), 32'd3);
        @(negedge clk);
        check_eq("held_idle_after", 32'(busy), 32'd0);

        // sweep: stride through the full input range plus the saturation edge
        for (int v = 0; v < 16384; v += 7) do_conv(14'(v), 1'b0);
        for (int v = 9995; v <= 10005; v++) do_conv(14'(v), 1'b0);
        do_conv(14'd16383, 1'b0);
        check_eq("bcd_16383", 32'(bcd_out), 32'h9999);
        check_eq("ovf_16383", 32'(ovf), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bin2bcd_seq
